// File: rtl/collision_scheduler.sv
// ---------------------------------------------------------------------------
// collision_scheduler: per-frame collision event collection and arbitration
// for the white and red balls, with valid/ack command issue. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module collision_scheduler #(
  parameter int ACK_TIMEOUT = 1023,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             whiteBallDR,
  input  logic             redBallDR,
  input  logic             borderDR,
  input  logic [5:0]       holeDR,
  output logic             whiteCmdValid,
  output logic [1:0]       whiteCmdType,
  output logic [2:0]       whiteCmdHole,
  input  logic             whiteCmdAck,
  output logic             redCmdValid,
  output logic [1:0]       redCmdType,
  output logic [2:0]       redCmdHole,
  input  logic             redCmdAck,
  output logic [CNT_W-1:0] whitePocketCnt,
  output logic [CNT_W-1:0] redPocketCnt,
  output logic             overrun,
  output logic             ackTimeout
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_WHITE, S_RED} state_t;
  state_t state, state_next;

  // Bank layout: [14] wB, [13] rB, [12] wr, [11:6] wH, [5:0] rH
  logic [14:0] ev_now, collect, pending;
  logic [1:0]  w_type_res, r_type_res;
  logic [2:0]  w_hole_res, r_hole_res;
  logic [TW-1:0] tmo_cnt;
  logic load_w, load_r, acked, tmo_hit, tmo_last;

  assign ev_now = {whiteBallDR & borderDR, redBallDR & borderDR,
                   whiteBallDR & redBallDR,
                   {6{whiteBallDR}} & holeDR, {6{redBallDR}} & holeDR};

  function automatic logic [2:0] lowest_set(input logic [5:0] v);
    lowest_set = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      if (v[k]) lowest_set = 3'(k);
    end
  endfunction

  always_comb begin
    w_type_res = 2'd0;
    r_type_res = 2'd0;
    if (|pending[11:6])  w_type_res = 2'd3;
    else if (pending[12]) w_type_res = 2'd2;
    else if (pending[14]) w_type_res = 2'd1;
    if (|pending[5:0])   r_type_res = 2'd3;
    else if (pending[12]) r_type_res = 2'd2;
    else if (pending[13]) r_type_res = 2'd1;
    w_hole_res = lowest_set(pending[11:6]);
    r_hole_res = lowest_set(pending[5:0]);
  end

  assign tmo_last = (tmo_cnt == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    state_next = state;
    load_w     = 1'b0;
    load_r     = 1'b0;
    acked      = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      S_IDLE: if (startOfFrame) state_next = S_ARB;
      S_ARB: begin
        if (w_type_res != 2'd0) begin
          state_next = S_WHITE;
          load_w     = 1'b1;
        end else if (r_type_res != 2'd0) begin
          state_next = S_RED;
          load_r     = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WHITE: begin
        acked   = whiteCmdAck;
        tmo_hit = !whiteCmdAck && tmo_last;
        if (acked || tmo_hit) begin
          if (r_type_res != 2'd0) begin
            state_next = S_RED;
            load_r     = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_RED: begin
        acked   = redCmdAck;
        tmo_hit = !redCmdAck && tmo_last;
        if (acked || tmo_hit) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state          <= S_IDLE;
      collect        <= '0;
      pending        <= '0;
      tmo_cnt        <= '0;
      whiteCmdValid  <= 1'b0;
      whiteCmdType   <= 2'd0;
      whiteCmdHole   <= 3'd0;
      redCmdValid    <= 1'b0;
      redCmdType     <= 2'd0;
      redCmdHole     <= 3'd0;
      whitePocketCnt <= '0;
      redPocketCnt   <= '0;
      overrun        <= 1'b0;
      ackTimeout     <= 1'b0;
    end else begin
      state <= state_next;

      // Events coincident with the snapshot go into the frame being closed.
      if (startOfFrame && state == S_IDLE) begin
        pending <= collect | ev_now;
        collect <= '0;
      end else begin
        collect <= collect | ev_now;
      end
      if (startOfFrame && state != S_IDLE) overrun <= 1'b1;
      if (tmo_hit) ackTimeout <= 1'b1;

      if (load_w || load_r)
        tmo_cnt <= '0;
      else if (state == S_WHITE || state == S_RED)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (state == S_WHITE && (acked || tmo_hit)) begin
        whiteCmdValid <= 1'b0;
        whiteCmdType  <= 2'd0;
        whiteCmdHole  <= 3'd0;
        if (acked && whiteCmdType == 2'd3 && whitePocketCnt != {CNT_W{1'b1}})
          whitePocketCnt <= whitePocketCnt + 1'b1;
      end
      if (state == S_RED && (acked || tmo_hit)) begin
        redCmdValid <= 1'b0;
        redCmdType  <= 2'd0;
        redCmdHole  <= 3'd0;
        if (acked && redCmdType == 2'd3 && redPocketCnt != {CNT_W{1'b1}})
          redPocketCnt <= redPocketCnt + 1'b1;
      end

      if (load_w) begin
        whiteCmdValid <= 1'b1;
        whiteCmdType  <= w_type_res;
        whiteCmdHole  <= (w_type_res == 2'd3) ? w_hole_res : 3'd0;
      end
      if (load_r) begin
        redCmdValid <= 1'b1;
        redCmdType  <= r_type_res;
        redCmdHole  <= (r_type_res == 2'd3) ? r_hole_res : 3'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_collision_scheduler.sv
// ---------------------------------------------------------------------------
// tb_collision_scheduler: directed self-checking bench for collision_scheduler
// ---------------------------------------------------------------------------
`default_nettype none

module tb_collision_scheduler;

  logic       clk = 1'b0;
  logic       resetN, startOfFrame, whiteBallDR, redBallDR, borderDR;
  logic [5:0] holeDR;
  logic       whiteCmdValid, whiteCmdAck, redCmdValid, redCmdAck;
  logic [1:0] whiteCmdType, redCmdType;
  logic [2:0] whiteCmdHole, redCmdHole;
  logic [3:0] whitePocketCnt, redPocketCnt;
  logic       overrun, ackTimeout;

  int checks = 0;
  int errors = 0;

  collision_scheduler #(.ACK_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .whiteBallDR(whiteBallDR), .redBallDR(redBallDR), .borderDR(borderDR),
    .holeDR(holeDR),
    .whiteCmdValid(whiteCmdValid), .whiteCmdType(whiteCmdType),
    .whiteCmdHole(whiteCmdHole), .whiteCmdAck(whiteCmdAck),
    .redCmdValid(redCmdValid), .redCmdType(redCmdType),
    .redCmdHole(redCmdHole), .redCmdAck(redCmdAck),
    .whitePocketCnt(whitePocketCnt), .redPocketCnt(redPocketCnt),
    .overrun(overrun), .ackTimeout(ackTimeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_px();
    whiteBallDR = 0; redBallDR = 0; borderDR = 0; holeDR = 6'd0; startOfFrame = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wv"}, whiteCmdValid, 0);
    chk({tag, "_wt"}, whiteCmdType, 0);
    chk({tag, "_wh"}, whiteCmdHole, 0);
    chk({tag, "_rv"}, redCmdValid, 0);
    chk({tag, "_rt"}, redCmdType, 0);
    chk({tag, "_rh"}, redCmdHole, 0);
    chk({tag, "_wpc"}, whitePocketCnt, 0);
    chk({tag, "_rpc"}, redPocketCnt, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_tmo"}, ackTimeout, 0);
  endtask

  initial begin
    resetN = 1; whiteCmdAck = 0; redCmdAck = 0;
    clear_px();
    step(); step();
    chk_all_zero("reset");
    resetN = 0;
    step();

    // Frame 1: white on border for 3 pixels, ack two cycles after valid.
    whiteBallDR = 1; borderDR = 1;
    step(); step(); step();
    clear_px();
    startOfFrame = 1;
    step();                       // edge N: snapshot, ARB
    startOfFrame = 0;
    chk("t1_arb_wv", whiteCmdValid, 0);
    step();                       // edge N+1
    chk("t1_wv", whiteCmdValid, 1);
    chk("t1_wt", whiteCmdType, 1);
    chk("t1_rv", redCmdValid, 0);
    step();
    chk("t1_hold_wv", whiteCmdValid, 1);
    chk("t1_hold_wt", whiteCmdType, 1);
    whiteCmdAck = 1;
    step();
    whiteCmdAck = 0;
    chk("t1_drop_wv", whiteCmdValid, 0);
    chk("t1_drop_wt", whiteCmdType, 0);
    chk("t1_drop_rv", redCmdValid, 0);
    step();
    chk("t1_idle_rv", redCmdValid, 0);

    // Frame 2: white on holes bit3+bit1, then white/red contact in the SOF cycle.
    whiteBallDR = 1; holeDR = 6'b001010;
    step();
    holeDR = 6'd0; redBallDR = 1; startOfFrame = 1;
    step();
    clear_px();
    step();
    chk("t2_wv", whiteCmdValid, 1);
    chk("t2_wt", whiteCmdType, 3);
    chk("t2_wh", whiteCmdHole, 1);
    chk("t2_rv_excl", redCmdValid, 0);
    whiteCmdAck = 1;
    step();
    whiteCmdAck = 0;
    chk("t2_wv_drop", whiteCmdValid, 0);
    chk("t2_rv", redCmdValid, 1);
    chk("t2_rt", redCmdType, 2);
    chk("t2_wpc", whitePocketCnt, 1);
    redCmdAck = 1;
    step();
    redCmdAck = 0;
    chk("t2_rv_drop", redCmdValid, 0);
    chk("t2_rpc", redPocketCnt, 0);
    chk("t2_wpc_keep", whitePocketCnt, 1);
    // Ack while nothing is valid must be ignored.
    whiteCmdAck = 1; redCmdAck = 1;
    step();
    whiteCmdAck = 0; redCmdAck = 0;
    chk("t2_stray_ack_wpc", whitePocketCnt, 1);
    chk("t2_stray_ack_rpc", redPocketCnt, 0);

    // Frame 3: no events.
    startOfFrame = 1;
    step();
    startOfFrame = 0;
    step();
    chk("t3_wv", whiteCmdValid, 0);
    chk("t3_rv", redCmdValid, 0);
    step();
    chk("t3_wv2", whiteCmdValid, 0);
    chk("t3_rv2", redCmdValid, 0);

    // Frames 4..23: red in hole 0, always acked; counter saturates at 15.
    for (int f = 0; f < 20; f++) begin
      redBallDR = 1; holeDR = 6'b000001; startOfFrame = 1;
      step();
      clear_px();
      step();
      chk($sformatf("t4_rv_f%0d", f), redCmdValid, 1);
      chk($sformatf("t4_rt_f%0d", f), redCmdType, 3);
      chk($sformatf("t4_rh_f%0d", f), redCmdHole, 0);
      redCmdAck = 1;
      step();
      redCmdAck = 0;
      chk($sformatf("t4_rpc_f%0d", f), redPocketCnt, (f < 15) ? f + 1 : 15);
      step();
    end

    // Timeout: white border, never acked; valid lasts 8 cycles.
    chk("t5_tmo_pre", ackTimeout, 0);
    whiteBallDR = 1; borderDR = 1; startOfFrame = 1;
    step();
    clear_px();
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("t5_hold_%0d", i), whiteCmdValid, 1);
    end
    step();
    chk("t5_drop_wv", whiteCmdValid, 0);
    chk("t5_drop_wt", whiteCmdType, 0);
    chk("t5_tmo", ackTimeout, 1);
    chk("t5_wpc", whitePocketCnt, 1);
    chk("t5_rv", redCmdValid, 0);
    step();

    // Overrun then reset mid-handshake.
    whiteBallDR = 1; borderDR = 1; startOfFrame = 1;
    step();
    clear_px();
    step();
    chk("t6_wv", whiteCmdValid, 1);
    chk("t6_ovr_pre", overrun, 0);
    startOfFrame = 1; whiteBallDR = 1; redBallDR = 1;
    step();
    clear_px();
    chk("t6_ovr", overrun, 1);
    chk("t6_wv_held", whiteCmdValid, 1);
    resetN = 1;
    step();
    resetN = 0;
    chk_all_zero("t6_rst");
    redBallDR = 1; borderDR = 1; startOfFrame = 1;
    step();
    clear_px();
    step();
    chk("t6_new_wv", whiteCmdValid, 0);
    chk("t6_new_rv", redCmdValid, 1);
    chk("t6_new_rt", redCmdType, 1);
    redCmdAck = 1;
    step();
    redCmdAck = 0;
    chk("t6_new_rdrop", redCmdValid, 0);
    chk("t6_new_wv2", whiteCmdValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
